// File: rtl/logic_op_scheduler.sv
// rtl/logic_op_scheduler.sv - round-robin scheduler sharing one registered bitwise logic unit
module logic_op_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    localparam int IDW    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [3*NUM_REQ-1:0]     req_op,
    input  logic [WIDTH*NUM_REQ-1:0] req_a,
    input  logic [WIDTH*NUM_REQ-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [IDW-1:0]           rsp_id,
    output logic [WIDTH-1:0]         rsp_data,
    output logic                     rsp_err,
    output logic                     busy
);

    localparam logic [2:0] OP_NOT  = 3'd0;
    localparam logic [2:0] OP_AND  = 3'd1;
    localparam logic [2:0] OP_OR   = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_XNOR = 3'd6;

    localparam logic [IDW:0]   NUM_REQ_W = (IDW+1)'(NUM_REQ);
    localparam logic [IDW-1:0] LAST_IDX  = IDW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [IDW-1:0]       rr_ptr;
    logic [IDW-1:0]       grant_off;
    logic [IDW-1:0]       grant_idx;
    logic [IDW:0]         grant_sum;
    logic                 grant_found;
    logic [2*NUM_REQ-1:0] valid_dbl;
    logic [NUM_REQ-1:0]   valid_rot;

    logic [2:0]       op_arr [NUM_REQ];
    logic [WIDTH-1:0] a_arr  [NUM_REQ];
    logic [WIDTH-1:0] b_arr  [NUM_REQ];

    logic [2:0]       cap_op;
    logic [WIDTH-1:0] cap_a;
    logic [WIDTH-1:0] cap_b;
    logic [IDW-1:0]   cap_id;

    logic [WIDTH-1:0] alu_data;
    logic             alu_err;

    // Split the flat request buses into per-requester slices
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign op_arr[i] = req_op[3*i +: 3];
        assign a_arr[i]  = req_a[WIDTH*i +: WIDTH];
        assign b_arr[i]  = req_b[WIDTH*i +: WIDTH];
    end

    // Rotate valids so rr_ptr sits at bit 0; the doubled copy provides the wrap-around
    assign valid_dbl = {req_valid, req_valid};
    assign valid_rot = valid_dbl[{1'b0, rr_ptr} +: NUM_REQ];

    // Lowest set bit of the rotated vector, mapped back to an absolute requester index
    always_comb begin
        grant_found = 1'b0;
        grant_off   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (valid_rot[k]) begin
                grant_found = 1'b1;
                grant_off   = IDW'(k);
            end
        end
        grant_sum = {1'b0, rr_ptr} + {1'b0, grant_off};
        if (grant_sum >= NUM_REQ_W) begin
            grant_sum = grant_sum - NUM_REQ_W;
        end
        grant_idx = grant_sum[IDW-1:0];
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake outputs; req_ready is held low while reset is asserted
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        rsp_valid = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (grant_found) begin
                    state_nxt = EXEC;
                    req_ready = rst_n ? (NUM_REQ'(1) << grant_idx) : '0;
                end
            end
            EXEC: begin
                state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Capture the granted request and advance the round-robin pointer on the accept edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            cap_op <= '0;
            cap_a  <= '0;
            cap_b  <= '0;
            cap_id <= '0;
        end else if (state == IDLE && grant_found) begin
            rr_ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + IDW'(1);
            cap_op <= op_arr[grant_idx];
            cap_a  <= a_arr[grant_idx];
            cap_b  <= b_arr[grant_idx];
            cap_id <= grant_idx;
        end
    end

    // Shared bitwise logic unit on the captured operands; opcode 7 is reported as illegal
    always_comb begin
        alu_data = '0;
        alu_err  = 1'b0;
        case (cap_op)
            OP_NOT:  alu_data = ~cap_a;
            OP_AND:  alu_data = cap_a & cap_b;
            OP_OR:   alu_data = cap_a | cap_b;
            OP_NAND: alu_data = ~(cap_a & cap_b);
            OP_NOR:  alu_data = ~(cap_a | cap_b);
            OP_XOR:  alu_data = cap_a ^ cap_b;
            OP_XNOR: alu_data = ~(cap_a ^ cap_b);
            default: alu_err  = 1'b1;
        endcase
    end

    // Result registers load at the end of EXEC and stay stable through RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data <= '0;
            rsp_err  <= 1'b0;
            rsp_id   <= '0;
        end else if (state == EXEC) begin
            rsp_data <= alu_data;
            rsp_err  <= alu_err;
            rsp_id   <= cap_id;
        end
    end

endmodule

// File: tb/tb_logic_op_scheduler.sv
// tb/tb_logic_op_scheduler.sv - self-checking bench for logic_op_scheduler
module tb_logic_op_scheduler;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int IDW = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [3*N-1:0]   req_op;
    logic [W*N-1:0]   req_a;
    logic [W*N-1:0]   req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [IDW-1:0]   rsp_id;
    logic [W-1:0]     rsp_data;
    logic             rsp_err;
    logic             busy;

    logic [2:0]   op_r [N];
    logic [W-1:0] a_r  [N];
    logic [W-1:0] b_r  [N];

    int checks = 0;
    int errors = 0;

    // reference model state: in-flight flag, cycles since the accept edge, rr pointer
    bit           m_busy;
    int           m_age;
    int           m_ptr;
    logic [IDW-1:0] m_id;
    logic [W-1:0] m_data;
    logic         m_err;
    logic [N-1:0] m_grant_vec;
    int           mg;
    logic [N-1:0] exp_ready;
    bit           exp_vis;
    int           cyc = 0;
    logic         prev_rsp_valid;

    logic [N-1:0] rec_grant[$];
    int           rec_grant_cyc[$];
    int           rec_rise_cyc[$];
    int           rec_id[$];
    logic [W-1:0] rec_data[$];
    logic         rec_err[$];

    int  refill   = 0;
    bit  rnd_mode = 1'b0;

    logic [7:0] sweep_exp [8] = '{8'h5A, 8'h05, 8'hAF, 8'hFA, 8'h50, 8'hAA, 8'h55, 8'h00};

    for (genvar i = 0; i < N; i++) begin : g_pack
        assign req_op[3*i +: 3] = op_r[i];
        assign req_a[W*i +: W]  = a_r[i];
        assign req_b[W*i +: W]  = b_r[i];
    end

    logic_op_scheduler #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            3'd0:    return ~a;
            3'd1:    return a & b;
            3'd2:    return a | b;
            3'd3:    return ~(a & b);
            3'd4:    return ~(a | b);
            3'd5:    return a ^ b;
            3'd6:    return ~(a ^ b);
            default: return '0;
        endcase
    endfunction

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic int gid(input int k);
        return (k < rec_id.size()) ? rec_id[k] : -1;
    endfunction
    function automatic int gdata(input int k);
        return (k < rec_data.size()) ? int'(rec_data[k]) : -1;
    endfunction
    function automatic int gerr(input int k);
        return (k < rec_err.size()) ? int'(rec_err[k]) : -1;
    endfunction
    function automatic int ggrant(input int k);
        return (k < rec_grant.size()) ? int'(rec_grant[k]) : -1;
    endfunction
    function automatic int ggcyc(input int k);
        return (k < rec_grant_cyc.size()) ? rec_grant_cyc[k] : -1000;
    endfunction
    function automatic int grise(input int k);
        return (k < rec_rise_cyc.size()) ? rec_rise_cyc[k] : -1000;
    endfunction

    // compare process: model predicts each cycle's outputs from inputs only, then advances
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_busy = 1'b0;
                m_age = 0;
                m_ptr = 0;
                m_grant_vec = '0;
                prev_rsp_valid = 1'b0;
            end else begin
                cyc++;
                mg = m_busy ? -1 : pick(req_valid, m_ptr);
                exp_ready = '0;
                if (mg >= 0) exp_ready[mg] = 1'b1;
                exp_vis = m_busy && (m_age >= 2);
                chk("m_req_ready", 32'(req_ready), 32'(exp_ready));
                chk("m_busy", 32'(busy), 32'(m_busy));
                chk("m_rsp_valid", 32'(rsp_valid), 32'(exp_vis));
                if (exp_vis) begin
                    chk("m_rsp_id", 32'(rsp_id), 32'(m_id));
                    chk("m_rsp_data", 32'(rsp_data), 32'(m_data));
                    chk("m_rsp_err", 32'(rsp_err), 32'(m_err));
                end
                if (req_ready != '0) begin
                    rec_grant.push_back(req_ready);
                    rec_grant_cyc.push_back(cyc);
                end
                if (rsp_valid && !prev_rsp_valid) rec_rise_cyc.push_back(cyc);
                if (rsp_valid && rsp_ready) begin
                    rec_id.push_back(int'(rsp_id));
                    rec_data.push_back(rsp_data);
                    rec_err.push_back(rsp_err);
                end
                prev_rsp_valid = rsp_valid;
                m_grant_vec = exp_ready;
                if (mg >= 0) begin
                    m_busy = 1'b1;
                    m_age  = 1;
                    m_ptr  = (mg + 1) % N;
                    m_id   = IDW'(mg);
                    m_data = ref_op(op_r[mg], a_r[mg], b_r[mg]);
                    m_err  = (op_r[mg] == 3'd7);
                end else if (exp_vis && rsp_ready) begin
                    m_busy = 1'b0;
                end else if (m_busy) begin
                    m_age++;
                end
            end
        end
    end

    task automatic new_payload(input int i);
        op_r[i] = 3'($urandom_range(0, 7));
        a_r[i]  = W'($urandom);
        b_r[i]  = W'($urandom);
    endtask

    task automatic set_req(input int i, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        op_r[i] = op;
        a_r[i]  = a;
        b_r[i]  = b;
        req_valid[i] = 1'b1;
    endtask

    task automatic clear_rec();
        rec_grant.delete();
        rec_grant_cyc.delete();
        rec_rise_cyc.delete();
        rec_id.delete();
        rec_data.delete();
        rec_err.delete();
    endtask

    // one clock: granted requesters drop or refill, others may act randomly
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (m_grant_vec[i]) begin
                if (refill > 0) begin
                    refill--;
                    new_payload(i);
                end else begin
                    req_valid[i] = 1'b0;
                end
            end else if (rnd_mode) begin
                if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    new_payload(i);
                    req_valid[i] = 1'b1;
                end else if (req_valid[i] && $urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
        end
        if (rnd_mode) rsp_ready = ($urandom_range(0, 2) != 0);
        #1;
    endtask

    task automatic wait_rsp(input int n, input string name);
        int k;
        k = 0;
        while (rec_id.size() < n && k < 200) begin
            step();
            k++;
        end
        chk({name, "_done"}, 32'(rec_id.size() >= n), 32'd1);
    endtask

    task automatic wait_rsp_valid(input string name);
        int k;
        k = 0;
        while (!rsp_valid && k < 20) begin
            step();
            k++;
        end
        chk({name, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            op_r[i] = '0;
            a_r[i]  = '0;
            b_r[i]  = '0;
        end
        @(negedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // fairness: all valid, 12 accepts
        clear_rec();
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) new_payload(i);
        req_valid = '1;
        refill = 8;
        wait_rsp(12, "fair");
        for (int k = 0; k < 12; k++) chk($sformatf("fair_id%0d", k), 32'(gid(k)), 32'(k % 4));
        chk("fair_spacing", 32'(ggcyc(1) - ggcyc(0)), 32'd3);

        // single request from requester 2
        clear_rec();
        set_req(2, 3'd1, 8'hF0, 8'h3C);
        wait_rsp(1, "single");
        chk("single_ready", 32'(ggrant(0)), 32'h4);
        chk("single_id", 32'(gid(0)), 32'd2);
        chk("single_data", 32'(gdata(0)), 32'h30);
        chk("single_err", 32'(gerr(0)), 32'd0);
        chk("single_latency", 32'(grise(0) - ggcyc(0)), 32'd2);

        // wrap-around: rr_ptr is 3, requesters 1 and 3 valid
        clear_rec();
        set_req(1, 3'd2, 8'h11, 8'h22);
        set_req(3, 3'd5, 8'hFF, 8'h0F);
        wait_rsp(2, "wrap");
        chk("wrap_grant0", 32'(ggrant(0)), 32'h8);
        chk("wrap_grant1", 32'(ggrant(1)), 32'h2);
        chk("wrap_data0", 32'(gdata(0)), 32'hF0);
        chk("wrap_data1", 32'(gdata(1)), 32'h33);

        // opcode sweep on requester 0
        for (int op = 0; op < 8; op++) begin
            clear_rec();
            set_req(0, 3'(op), 8'hA5, 8'h0F);
            wait_rsp(1, "sweep");
            chk($sformatf("sweep_data_op%0d", op), 32'(gdata(0)), 32'(sweep_exp[op]));
            chk($sformatf("sweep_err_op%0d", op), 32'(gerr(0)), 32'(op == 7));
        end

        // response backpressure
        clear_rec();
        rsp_ready = 1'b0;
        set_req(1, 3'd5, 8'h3C, 8'hFF);
        wait_rsp_valid("bp");
        set_req(0, 3'd1, 8'hFF, 8'h0F);
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_data", 32'(rsp_data), 32'hC3);
            chk("bp_id", 32'(rsp_id), 32'd1);
            chk("bp_err", 32'(rsp_err), 32'd0);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            chk("bp_busy", 32'(busy), 32'd1);
            step();
        end
        rsp_ready = 1'b1;
        step();
        chk("bp_next_accept", 32'(req_ready), 32'h1);
        wait_rsp(2, "bp");
        chk("bp_id0", 32'(gid(0)), 32'd1);
        chk("bp_id1", 32'(gid(1)), 32'd0);
        chk("bp_data1", 32'(gdata(1)), 32'h0F);

        // randomized traffic against the model
        rnd_mode = 1'b1;
        repeat (600) step();
        rnd_mode = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (6) step();

        // asynchronous reset while a response is pending
        clear_rec();
        rsp_ready = 1'b0;
        set_req(2, 3'd2, 8'h12, 8'h21);
        wait_rsp_valid("arst");
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        req_valid = '0;
        set_req(2, 3'd1, 8'hF0, 8'hFF);
        set_req(3, 3'd0, 8'h0F, 8'h00);
        #1;
        chk("arst_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        wait_rsp(2, "arst");
        chk("arst_grant0", 32'(ggrant(0)), 32'h4);
        chk("arst_id0", 32'(gid(0)), 32'd2);
        chk("arst_data0", 32'(gdata(0)), 32'hF0);
        chk("arst_id1", 32'(gid(1)), 32'd3);
        chk("arst_data1", 32'(gdata(1)), 32'hF0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
